uart_rx_frontend: RTL

- Serial receive front end for the UART memory bridge.
- Sits directly upstream of the UART memory controller and drives its `recv_data`, `recv_fault` and `uart_recv_using` inputs.
- Oversamples the asynchronous `rx` line and reassembles 8N1 frames (start, 8 data bits LSB first, 1 stop).
- Presents each byte with a busy/done handshake; the falling edge of `uart_recv_using` marks a completed byte.

---
 rtl/uart_rx_frontend_pkg.sv | 24 ++
 rtl/uart_rx_frontend_if.sv | 21 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_frontend.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_rx_frontend_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and
// the baud divider helper used by both receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  // Clocks per oversample tick, truncated and clamped so a tick always exists.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Byte-level handshake between the receive front end and the memory controller.
interface uart_rx_frontend_if;
  logic [7:0] recv_data;
  logic       recv_fault;
  logic       uart_recv_using;
  logic       recv_valid;

  modport master (
    output recv_data,
    output recv_fault,
    output uart_recv_using,
    output recv_valid
  );

  modport slave (
    input recv_data,
    input recv_fault,
    input uart_recv_using,
    input recv_valid
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; one-clock pulse every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; with DIV=1 the counter sits at 0 and ticks every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 serial receiver: synchronizes rx, majority-votes three centre samples
// per bit and hands each byte to the controller with a busy/done handshake.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  uart_rx_frontend_if.master     bus
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] S_PRE  = SCW'(M - 1);
  localparam logic [SCW-1:0] S_MID  = SCW'(M);
  localparam logic [SCW-1:0] S_DEC  = SCW'(M + 1);
  localparam logic [SCW-1:0] S_END  = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

  logic           tick;
  logic           rx_meta;
  logic           rx_s;
  uart_state_t    state;
  logic [SCW-1:0] scnt;
  logic [BCW-1:0] bcnt;
  logic [7:0]     shift;
  logic           samp_a;
  logic           samp_b;
  logic           maj;
  logic           done_pend;
  logic [7:0]     data_q;
  logic           fault_q;
  logic           using_q;
  logic           valid_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The third vote is the live sample taken on the decision tick itself.
  assign maj = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

  // Frame FSM; the done handshake runs every clock so it lands one clock after the stop decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shift     <= '0;
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      done_pend <= 1'b0;
      data_q    <= '0;
      fault_q   <= 1'b0;
      using_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (done_pend) begin
        done_pend <= 1'b0;
        using_q   <= 1'b0;
        valid_q   <= 1'b1;
      end

      if (tick) begin
        if (scnt == S_PRE) samp_a <= rx_s;
        if (scnt == S_MID) samp_b <= rx_s;

        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              scnt  <= '0;
            end
          end

          START: begin
            if (scnt == S_DEC && maj) begin
              state <= IDLE;
              scnt  <= '0;
            end else if (scnt == S_END) begin
              state <= DATA;
              scnt  <= '0;
              bcnt  <= '0;
            end else begin
              if (scnt == S_DEC) using_q <= 1'b1;
              scnt <= scnt + SCW'(1);
            end
          end

          DATA: begin
            if (scnt == S_DEC) shift <= {maj, shift[7:1]};
            if (scnt == S_END) begin
              scnt <= '0;
              if (bcnt == B_LAST) begin
                state <= STOP;
              end else begin
                bcnt <= bcnt + BCW'(1);
              end
            end else begin
              scnt <= scnt + SCW'(1);
            end
          end

          STOP: begin
            if (scnt == S_DEC) begin
              data_q    <= shift;
              fault_q   <= ~maj;
              done_pend <= 1'b1;
              scnt      <= '0;
              state     <= maj ? IDLE : BREAK;
            end else begin
              scnt <= scnt + SCW'(1);
            end
          end

          BREAK: begin
            if (rx_s) state <= IDLE;
          end

          default: begin
            state <= IDLE;
            scnt  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.recv_data       = data_q;
  assign bus.recv_fault      = fault_q;
  assign bus.uart_recv_using = using_q;
  assign bus.recv_valid      = valid_q;

endmodule
